// File: rtl/timeout_timer_sitcpxg_if.sv
// Command/status bundle for the timeout timer.
// The master side drives the ticks and commands; the slave side is the timer.
interface timeout_timer_sitcpxg_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 i_tim_1us;
  logic                 i_tim_1ms;
  logic                 i_tim_1s;
  logic                 i_start;
  logic                 i_stop;
  logic [1:0]           i_unit;
  logic [CNT_WIDTH-1:0] i_timeout;
  logic                 i_periodic;
  logic                 i_err_clr;
  logic                 o_expire;
  logic                 o_busy;
  logic [CNT_WIDTH-1:0] o_remain;
  logic                 o_tick_err;

  modport master (
    output i_tim_1us, i_tim_1ms, i_tim_1s, i_start, i_stop,
           i_unit, i_timeout, i_periodic, i_err_clr,
    input  o_expire, o_busy, o_remain, o_tick_err
  );

  modport slave (
    input  i_tim_1us, i_tim_1ms, i_tim_1s, i_start, i_stop,
           i_unit, i_timeout, i_periodic, i_err_clr,
    output o_expire, o_busy, o_remain, o_tick_err
  );
endinterface

// File: rtl/timeout_timer_sitcpxg.sv
// One-shot / periodic timeout timer counting us, ms or s ticks, with an
// independent monitor that flags a malformed tick stream.
module timeout_timer_sitcpxg #(
  parameter int CNT_WIDTH = 16,
  parameter int US_MIN    = 156,
  parameter int US_MAX    = 157
) (
  input  logic                   clk,
  input  logic                   rst_n,
  timeout_timer_sitcpxg_if.slave bus
);

  // Gap counter is at least 9 bits and wide enough to hold US_MAX+1.
  localparam int GAP_W = ($clog2(US_MAX + 2) > 9) ? $clog2(US_MAX + 2) : 9;
  localparam logic [GAP_W-1:0] L_US_MIN = GAP_W'(US_MIN);
  localparam logic [GAP_W-1:0] L_US_MAX = GAP_W'(US_MAX);
  localparam logic [GAP_W-1:0] L_US_LATE = GAP_W'(US_MAX + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_remain;
  logic [CNT_WIDTH-1:0] r_timeout;
  logic [1:0]           r_unit;
  logic                 r_periodic;
  logic                 r_expire;

  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] w_remain_nxt;
  logic [CNT_WIDTH-1:0] w_timeout_nxt;
  logic [1:0]           w_unit_nxt;
  logic                 w_periodic_nxt;
  logic                 w_expire_nxt;
  logic                 w_tick;

  logic [GAP_W-1:0]     r_gap;
  logic                 r_armed;
  logic                 r_tick_err;
  logic                 w_gap_bad;
  logic                 w_gap_late;
  logic                 w_hier_bad;
  logic                 w_fault;

  // Select the tick stream chosen by the latched unit; the reserved code never ticks.
  always_comb begin
    w_tick = 1'b0;
    case (r_unit)
      2'b00:   w_tick = bus.i_tim_1us;
      2'b01:   w_tick = bus.i_tim_1ms;
      2'b10:   w_tick = bus.i_tim_1s;
      default: w_tick = 1'b0;
    endcase
  end

  // Next-state logic: STOP beats START beats a tick; START cycles ignore ticks.
  always_comb begin
    w_state_nxt    = r_state;
    w_remain_nxt   = r_remain;
    w_timeout_nxt  = r_timeout;
    w_unit_nxt     = r_unit;
    w_periodic_nxt = r_periodic;
    w_expire_nxt   = 1'b0;
    if (bus.i_stop) begin
      w_state_nxt  = IDLE;
      w_remain_nxt = '0;
    end else if (bus.i_start && (bus.i_unit != 2'b11)) begin
      if (bus.i_timeout == '0) begin
        w_expire_nxt = 1'b1;
        w_state_nxt  = IDLE;
        w_remain_nxt = '0;
      end else begin
        w_state_nxt    = RUN;
        w_remain_nxt   = bus.i_timeout;
        w_timeout_nxt  = bus.i_timeout;
        w_unit_nxt     = bus.i_unit;
        w_periodic_nxt = bus.i_periodic;
      end
    end else if ((r_state == RUN) && w_tick) begin
      if (r_remain > CNT_WIDTH'(1)) begin
        w_remain_nxt = r_remain - CNT_WIDTH'(1);
      end else begin
        w_expire_nxt = 1'b1;
        if (r_periodic) begin
          w_remain_nxt = r_timeout;
        end else begin
          w_state_nxt  = IDLE;
          w_remain_nxt = '0;
        end
      end
    end
  end

  // Timer registers; reset discards any latched settings.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_remain   <= '0;
      r_timeout  <= '0;
      r_unit     <= 2'b00;
      r_periodic <= 1'b0;
      r_expire   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_remain   <= w_remain_nxt;
      r_timeout  <= w_timeout_nxt;
      r_unit     <= w_unit_nxt;
      r_periodic <= w_periodic_nxt;
      r_expire   <= w_expire_nxt;
    end
  end

  // Fault detection: r_gap equals the clocks elapsed since the last us pulse.
  always_comb begin
    w_gap_bad  = r_armed && bus.i_tim_1us && ((r_gap < L_US_MIN) || (r_gap > L_US_MAX));
    w_gap_late = r_armed && !bus.i_tim_1us && (r_gap == L_US_LATE);
    w_hier_bad = (bus.i_tim_1ms && !bus.i_tim_1us) || (bus.i_tim_1s && !bus.i_tim_1ms);
    w_fault    = w_gap_bad || w_gap_late || w_hier_bad;
  end

  // Monitor registers: saturating gap count, arming on the first pulse, sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap      <= '0;
      r_armed    <= 1'b0;
      r_tick_err <= 1'b0;
    end else begin
      if (bus.i_tim_1us) begin
        r_gap   <= GAP_W'(1);
        r_armed <= 1'b1;
      end else if (r_gap != '1) begin
        r_gap <= r_gap + GAP_W'(1);
      end
      if (w_fault) begin
        r_tick_err <= 1'b1;
      end else if (bus.i_err_clr) begin
        r_tick_err <= 1'b0;
      end
    end
  end

  assign bus.o_expire   = r_expire;
  assign bus.o_busy     = (r_state == RUN);
  assign bus.o_remain   = r_remain;
  assign bus.o_tick_err = r_tick_err;

endmodule

// File: tb/tb_timeout_timer_sitcpxg.sv
// Directed bench for the timeout timer with a cycle-level behavioural model.
module tb_timeout_timer_sitcpxg;

  localparam int CNT_WIDTH = 16;
  localparam int US_MIN    = 156;
  localparam int US_MAX    = 157;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cycSinceUs;

  // Model state: timing expressed as ticks counted since the last (re)load.
  bit   mRun;
  int   mTicks;
  int   mTo;
  int   mUnit;
  bit   mPer;
  bit   mExpire;
  bit   mErr;
  int   mCyc;
  int   mLastUs;

  timeout_timer_sitcpxg_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

  timeout_timer_sitcpxg #(
    .CNT_WIDTH(CNT_WIDTH),
    .US_MIN   (US_MIN),
    .US_MAX   (US_MAX)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int modelRemain();
    return mRun ? (mTo - mTicks) : 0;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d required %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model advanced on each rising edge, cleared by reset.
  initial begin
    bit tickSel;
    bit fault;
    int gap;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mRun = 0; mTicks = 0; mTo = 0; mUnit = 0; mPer = 0;
        mExpire = 0; mErr = 0; mCyc = 0; mLastUs = -1;
      end else begin
        mCyc++;
        case (mUnit)
          0:       tickSel = bus.i_tim_1us;
          1:       tickSel = bus.i_tim_1ms;
          2:       tickSel = bus.i_tim_1s;
          default: tickSel = 0;
        endcase
        mExpire = 0;
        if (bus.i_stop) begin
          mRun = 0;
        end else if (bus.i_start && bus.i_unit != 2'b11) begin
          if (bus.i_timeout == 0) begin
            mExpire = 1;
            mRun = 0;
          end else begin
            mRun = 1; mTicks = 0; mTo = int'(bus.i_timeout);
            mUnit = int'(bus.i_unit); mPer = bus.i_periodic;
          end
        end else if (mRun && tickSel) begin
          mTicks++;
          if (mTicks == mTo) begin
            mExpire = 1;
            mTicks = 0;
            if (!mPer) mRun = 0;
          end
        end
        fault = 0;
        gap = mCyc - mLastUs;
        if (bus.i_tim_1us) begin
          if (mLastUs >= 0 && (gap < US_MIN || gap > US_MAX)) fault = 1;
          mLastUs = mCyc;
        end else if (mLastUs >= 0 && gap == US_MAX + 1) begin
          fault = 1;
        end
        if (bus.i_tim_1ms && !bus.i_tim_1us) fault = 1;
        if (bus.i_tim_1s && !bus.i_tim_1ms) fault = 1;
        if (fault) mErr = 1;
        else if (bus.i_err_clr) mErr = 0;
      end
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    checkOutput("model_expire", int'(bus.o_expire), int'(mExpire));
    checkOutput("model_busy", int'(bus.o_busy), int'(mRun));
    checkOutput("model_remain", int'(bus.o_remain), modelRemain());
    checkOutput("model_tick_err", int'(bus.o_tick_err), int'(mErr));
  end

  // Drive one cycle of pulse inputs, then release them.
  task automatic applyStimulus(input logic us, input logic ms, input logic s,
                               input logic st, input logic sp, input logic clr);
    bus.i_tim_1us = us; bus.i_tim_1ms = ms; bus.i_tim_1s = s;
    bus.i_start = st; bus.i_stop = sp; bus.i_err_clr = clr;
    @(negedge clk);
    if (us) cycSinceUs = 0;
    else cycSinceUs++;
    bus.i_tim_1us = 0; bus.i_tim_1ms = 0; bus.i_tim_1s = 0;
    bus.i_start = 0; bus.i_stop = 0; bus.i_err_clr = 0;
  endtask

  // Emit a us pulse exactly 'gap' clocks after the previous one.
  task automatic usPulse(input int gap, input logic ms, input logic sp, input logic st);
    while (cycSinceUs < gap - 1) applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, ms, 0, st, sp, 0);
  endtask

  initial begin
    checks = 0; errors = 0; cycSinceUs = 0;
    rst_n = 1'b1;
    bus.i_tim_1us = 0; bus.i_tim_1ms = 0; bus.i_tim_1s = 0;
    bus.i_start = 0; bus.i_stop = 0; bus.i_err_clr = 0;
    bus.i_unit = 2'b00; bus.i_timeout = '0; bus.i_periodic = 0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_expire", int'(bus.o_expire), 0);
    checkOutput("reset_busy", int'(bus.o_busy), 0);
    checkOutput("reset_remain", int'(bus.o_remain), 0);
    checkOutput("reset_tick_err", int'(bus.o_tick_err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] one-shot us countdown");
    applyStimulus(1, 0, 0, 0, 0, 0);
    bus.i_unit = 2'b00; bus.i_timeout = 16'd3; bus.i_periodic = 0;
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("os_busy_start", int'(bus.o_busy), 1);
    checkOutput("os_remain_3", int'(bus.o_remain), 3);
    usPulse(156, 0, 0, 0);
    checkOutput("os_remain_2", int'(bus.o_remain), 2);
    usPulse(157, 0, 0, 0);
    checkOutput("os_remain_1", int'(bus.o_remain), 1);
    checkOutput("os_no_expire_yet", int'(bus.o_expire), 0);
    usPulse(156, 0, 0, 0);
    checkOutput("os_expire", int'(bus.o_expire), 1);
    checkOutput("os_remain_0", int'(bus.o_remain), 0);
    checkOutput("os_busy_drop", int'(bus.o_busy), 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("os_expire_single", int'(bus.o_expire), 0);

    $display("[TB] periodic ms timer");
    bus.i_unit = 2'b01; bus.i_timeout = 16'd2; bus.i_periodic = 1;
    applyStimulus(0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      usPulse((i % 2 == 0) ? 156 : 157, (i % 3 == 0), 0, 0);
      if (i == 3) checkOutput("per_remain_1", int'(bus.o_remain), 1);
      if (i == 6 || i == 12) begin
        checkOutput("per_expire", int'(bus.o_expire), 1);
        checkOutput("per_reload", int'(bus.o_remain), 2);
        checkOutput("per_busy", int'(bus.o_busy), 1);
      end
    end
    checkOutput("per_no_tick_err", int'(bus.o_tick_err), 0);

    $display("[TB] zero timeout and reserved unit");
    bus.i_unit = 2'b00; bus.i_timeout = 16'd0;
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("zero_expire", int'(bus.o_expire), 1);
    checkOutput("zero_busy", int'(bus.o_busy), 0);
    checkOutput("zero_remain", int'(bus.o_remain), 0);
    bus.i_unit = 2'b11; bus.i_timeout = 16'd5;
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("rsv_idle_busy", int'(bus.o_busy), 0);
    checkOutput("rsv_idle_remain", int'(bus.o_remain), 0);
    bus.i_unit = 2'b00; bus.i_timeout = 16'd7; bus.i_periodic = 0;
    applyStimulus(0, 0, 0, 1, 0, 0);
    bus.i_unit = 2'b11; bus.i_timeout = 16'd9;
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("rsv_run_remain", int'(bus.o_remain), 7);
    checkOutput("rsv_run_busy", int'(bus.o_busy), 1);

    $display("[TB] same-cycle command priority");
    applyStimulus(0, 0, 0, 0, 1, 0);
    bus.i_unit = 2'b00; bus.i_timeout = 16'd1;
    applyStimulus(0, 0, 0, 1, 0, 0);
    usPulse(156, 0, 1, 0);
    checkOutput("stop_tick_expire", int'(bus.o_expire), 0);
    checkOutput("stop_tick_busy", int'(bus.o_busy), 0);
    checkOutput("stop_tick_remain", int'(bus.o_remain), 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    bus.i_timeout = 16'd4;
    usPulse(157, 0, 0, 1);
    checkOutput("start_tick_remain", int'(bus.o_remain), 4);
    checkOutput("start_tick_expire", int'(bus.o_expire), 0);
    usPulse(156, 0, 0, 0);
    checkOutput("start_tick_next", int'(bus.o_remain), 3);
    applyStimulus(0, 0, 0, 0, 1, 0);

    $display("[TB] tick monitor");
    usPulse(156, 0, 0, 0);
    usPulse(157, 0, 0, 0);
    checkOutput("mon_good_gaps", int'(bus.o_tick_err), 0);
    usPulse(155, 0, 0, 0);
    checkOutput("mon_short_gap", int'(bus.o_tick_err), 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("mon_clear", int'(bus.o_tick_err), 0);
    usPulse(157, 0, 0, 0);
    for (int k = 1; k <= 158; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      if (k == 157) checkOutput("mon_gap157_ok", int'(bus.o_tick_err), 0);
      if (k == 158) checkOutput("mon_gap158_err", int'(bus.o_tick_err), 1);
    end
    usPulse(200, 0, 0, 0);
    usPulse(156, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("mon_clear2", int'(bus.o_tick_err), 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("mon_ms_alone", int'(bus.o_tick_err), 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("mon_clear3", int'(bus.o_tick_err), 0);
    applyStimulus(0, 1, 0, 0, 0, 1);
    checkOutput("mon_fault_beats_clr", int'(bus.o_tick_err), 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("mon_s_alone", int'(bus.o_tick_err), 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("mon_clear4", int'(bus.o_tick_err), 0);

    $display("[TB] reset mid-run");
    usPulse(156, 0, 0, 0);
    bus.i_unit = 2'b00; bus.i_timeout = 16'd5; bus.i_periodic = 1;
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("rst_pre_remain", int'(bus.o_remain), 5);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("rst_pre_err", int'(bus.o_tick_err), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_expire", int'(bus.o_expire), 0);
    checkOutput("rst_async_busy", int'(bus.o_busy), 0);
    checkOutput("rst_async_remain", int'(bus.o_remain), 0);
    checkOutput("rst_async_err", int'(bus.o_tick_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 300; k++) applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("rst_disarmed", int'(bus.o_tick_err), 0);
    for (int k = 0; k < 6; k++) usPulse(156, 0, 0, 0);
    checkOutput("rst_post_busy", int'(bus.o_busy), 0);
    checkOutput("rst_post_remain", int'(bus.o_remain), 0);
    checkOutput("rst_post_err", int'(bus.o_tick_err), 0);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timeout_timer_sitcpxg.md
TIMEOUT_TIMER_SITCPXG -- requirements
Module: timeout_timer_sitcpxg

Interface
REQ-001 SHALL provide parameter CNT_WIDTH, default 16: width of the timeout count.
REQ-002 SHALL provide parameter US_MIN, default 156: minimum legal clock count between TIM_1US pulses.
REQ-003 SHALL provide parameter US_MAX, default 157: maximum legal clock count between TIM_1US pulses.
REQ-004 CLK  in  1  system clock, 156.25 MHz.
REQ-005 RST_N  in  1  reset, asynchronous, active-low.
REQ-006 TIM_1US  in  1  1 us tick, one-cycle pulse.
REQ-007 TIM_1MS  in  1  1 ms tick; legal only coincident with TIM_1US.
REQ-008 TIM_1S  in  1  1 s tick; legal only coincident with TIM_1MS.
REQ-009 START  in  1  pulse: latch UNIT/TIMEOUT/PERIODIC and begin timing.
REQ-010 STOP  in  1  pulse: abort timing.
REQ-011 UNIT  in  2  tick select: 00 us, 01 ms, 10 s, 11 reserved.
REQ-012 TIMEOUT  in  CNT_WIDTH  number of selected ticks until expiry.
REQ-013 PERIODIC  in  1  1 = auto-reload after expiry.
REQ-014 ERR_CLR  in  1  clears TICK_ERR.
REQ-015 EXPIRE  out  1  one-cycle expiry pulse, registered.
REQ-016 BUSY  out  1  1 while in RUN.
REQ-017 REMAIN  out  CNT_WIDTH  ticks remaining.
REQ-018 TICK_ERR  out  1  sticky tick-stream fault flag.

Function
REQ-019 SHALL implement two states: IDLE and RUN; BUSY = (state == RUN).
REQ-020 Command priority SHALL be STOP > START > tick, evaluated per cycle.
REQ-021 STOP SHALL force IDLE and REMAIN=0 next cycle; no EXPIRE is produced, even if a terminal tick occurs in the same cycle.
REQ-022 START with UNIT!=11 and TIMEOUT!=0 SHALL, from either state, latch the inputs, set REMAIN=TIMEOUT, and enter RUN next cycle; any tick in that cycle is ignored.
REQ-023 START with TIMEOUT==0 SHALL pulse EXPIRE the next cycle, set state IDLE, and set REMAIN=0.
REQ-024 START with UNIT==11 SHALL be ignored; state and REMAIN are unchanged.
REQ-025 In RUN, each cycle with the latched tick asserted and REMAIN>1 SHALL decrement REMAIN by 1.
REQ-026 In RUN, a latched tick with REMAIN==1 SHALL pulse EXPIRE the next cycle (latency 1 clock from tick).
- PERIODIC=1: REMAIN reloads the latched TIMEOUT; state stays RUN.
- PERIODIC=0: REMAIN=0; state goes to IDLE.
REQ-027 Ticks in IDLE SHALL have no effect; REMAIN never wraps below 0.
REQ-028 Tick monitor SHALL count clocks since the last TIM_1US in a saturating counter of at least 9 bits, and SHALL arm on the first TIM_1US after reset.
REQ-029 Once armed, TIM_1US arriving with gap <US_MIN or >US_MAX SHALL set TICK_ERR; the gap is measured pulse to pulse, so adjacent cycles give a gap of 1.
REQ-030 Once armed, gap reaching US_MAX+1 without a pulse SHALL set TICK_ERR immediately.
REQ-031 TIM_1MS without TIM_1US, or TIM_1S without TIM_1MS, in the same cycle SHALL set TICK_ERR.
REQ-032 ERR_CLR SHALL clear TICK_ERR next cycle; a new fault in the same cycle wins, and TICK_ERR stays 1.
REQ-033 The monitor SHALL operate independently of state; TICK_ERR does not stop timing.

Reset
REQ-034 RST_N low SHALL asynchronously force IDLE, EXPIRE=0, BUSY=0, REMAIN=0, TICK_ERR=0, and disarm the monitor.
REQ-035 Reset mid-RUN SHALL discard latched settings; no EXPIRE follows reset release.

Verification
REQ-036 UNIT=00, TIMEOUT=3, PERIODIC=0, ticks every 156/157 clocks -> REMAIN 3,2,1,0; one EXPIRE the cycle after the 3rd tick; BUSY drops with it.
REQ-037 UNIT=01, TIMEOUT=2, PERIODIC=1 -> EXPIRE after every 2nd TIM_1MS; REMAIN reloads to 2; BUSY stays 1.
REQ-038 START with TIMEOUT=0 -> EXPIRE next cycle, BUSY stays 0; START with UNIT=11 in IDLE -> no state change.
REQ-039 In RUN with REMAIN=1, STOP and tick in the same cycle -> no EXPIRE, IDLE, REMAIN=0; START and tick in the same cycle -> REMAIN=TIMEOUT, tick ignored.
REQ-040 Monitor: TIM_1US gaps 156,157,155 -> TICK_ERR set at the 155 pulse; no pulse for 158 clocks -> TICK_ERR; TIM_1MS alone -> TICK_ERR; ERR_CLR -> 0.
REQ-041 RST_N low mid-RUN (REMAIN=5) -> all outputs 0 immediately; no EXPIRE after release.
